// File: rtl/acl_responder.sv
// SPI mode-0 responder emulating the accelerometer side of the ACL link:
// serves a 64 x 8 register file through the 0x0A write / 0x0B read commands.
module acl_responder #(
   parameter logic [7:0] DEVID_AD  = 8'hAD,
   parameter logic [7:0] DEVID_MST = 8'h1D,
   parameter logic [7:0] PARTID    = 8'hF2
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       CSn,
   input  logic       SCLK,
   input  logic       MOSI,
   output logic       MISO,
   input  logic       sample_valid,
   input  logic [7:0] sample_x,
   input  logic [7:0] sample_y,
   input  logic [7:0] sample_z,
   output logic       int1,
   output logic       wr_valid,
   output logic [5:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] power_ctl
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, DISCARD} state_t;

   logic       cs_s1, cs_s2;
   logic       sclk_s1, sclk_s2, sclk_s3;
   logic       mosi_s1, mosi_s2;
   logic       rise, fall;

   state_t     state;
   logic [2:0] bit_cnt;
   logic [6:0] rx;
   logic       byte_done;
   logic [7:0] byte_val;
   logic       wr_flag;
   logic [5:0] ptr;
   logic [7:0] tx;
   logic       tx_bit;
   logic [7:0] regs [64];
   logic       int1_set, int1_clr;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         cs_s1   <= CSn;
         cs_s2   <= cs_s1;
         sclk_s1 <= SCLK;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         mosi_s1 <= MOSI;
         mosi_s2 <= mosi_s1;
      end
   end

   assign rise      = sclk_s2 & ~sclk_s3;
   assign fall      = ~sclk_s2 & sclk_s3;
   assign power_ctl = regs[6'h2D];
   assign int1_set  = sample_valid && (power_ctl[1:0] == 2'b10);
   assign int1_clr  = !cs_s2 && (state == RDATA) && byte_done && (ptr == 6'h0A);

   // A completed byte is latched on the 8th rise and acted on one cycle later,
   // which puts write commits and tx reloads 4 cycles after the pin edge.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         rx        <= '0;
         byte_done <= 1'b0;
         byte_val  <= '0;
         wr_flag   <= 1'b0;
         ptr       <= '0;
         tx        <= '0;
         tx_bit    <= 1'b0;
         MISO      <= 1'b0;
         int1      <= 1'b0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         for (int unsigned i = 0; i < 64; i++) regs[i] <= '0;
         regs[0] <= DEVID_AD;
         regs[1] <= DEVID_MST;
         regs[2] <= PARTID;
      end else begin
         wr_valid  <= 1'b0;
         byte_done <= 1'b0;
         MISO      <= (state == RDATA) && tx_bit;

         if (sample_valid) begin
            regs[6'h08] <= sample_x;
            regs[6'h09] <= sample_y;
            regs[6'h0A] <= sample_z;
         end

         if (int1_set)      int1 <= 1'b1;
         else if (int1_clr) int1 <= 1'b0;

         if (cs_s2) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tx_bit  <= 1'b0;
         end else begin
            if (rise && state != IDLE) begin
               rx      <= {rx[5:0], mosi_s2};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  byte_done <= 1'b1;
                  byte_val  <= {rx, mosi_s2};
               end
            end

            // tx is a snapshot, so a concurrent sample load cannot tear a byte
            if (fall && state == RDATA) begin
               tx_bit <= tx[7];
               tx     <= {tx[6:0], 1'b0};
            end

            case (state)
               IDLE: begin
                  state   <= CMD;
                  bit_cnt <= '0;
               end
               CMD: if (byte_done) begin
                  case (byte_val)
                     8'h0A: begin state <= ADDR; wr_flag <= 1'b1; end
                     8'h0B: begin state <= ADDR; wr_flag <= 1'b0; end
                     default: state <= DISCARD;
                  endcase
               end
               ADDR: if (byte_done) begin
                  ptr <= byte_val[5:0];
                  if (wr_flag) begin
                     state <= WDATA;
                  end else begin
                     state <= RDATA;
                     tx    <= regs[byte_val[5:0]];
                  end
               end
               WDATA: if (byte_done) begin
                  if (ptr >= 6'h1F) begin
                     regs[ptr] <= byte_val;
                     wr_valid  <= 1'b1;
                     wr_addr   <= ptr;
                     wr_data   <= byte_val;
                  end
                  ptr <= ptr + 6'd1;
               end
               RDATA: if (byte_done) begin
                  ptr <= ptr + 6'd1;
                  tx  <= regs[ptr + 6'd1];
               end
               DISCARD: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
